stack_arbiter: RTL

STACK_ARBITER -- requirements
Module: stack_arbiter

---
 rtl/stack_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/stack_arbiter.sv
// stack_arbiter
//   Two-requester round-robin arbiter in front of a LIFO stack datapath.
//   One operation is in flight at a time: IDLE picks a winner and checks
//   legality, EXEC strobes the datapath, WAIT captures pop data, and RESP
//   acknowledges the winner.
// Ports
//   clk, rst_n              : clock, synchronous active-low reset
//   ena                     : enables new grants (in-flight op always completes)
//   a_req/a_op/a_wdata      : requester A request, op (0 push, 1 pop), push data
//   a_ack/a_err/a_rdata     : requester A completion pulse, reject flag, pop data
//   b_*                     : same as a_* for requester B
//   stk_push/stk_pop        : one-cycle strobes to the stack datapath
//   stk_wdata/stk_rdata     : push data out, pop data in (valid a cycle after pop)
//   count/full/empty        : current occupancy
module stack_arbiter #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned DW    = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   ena,
  input  logic                   a_req,
  input  logic                   a_op,
  input  logic [DW-1:0]          a_wdata,
  output logic                   a_ack,
  output logic                   a_err,
  output logic [DW-1:0]          a_rdata,
  input  logic                   b_req,
  input  logic                   b_op,
  input  logic [DW-1:0]          b_wdata,
  output logic                   b_ack,
  output logic                   b_err,
  output logic [DW-1:0]          b_rdata,
  output logic                   stk_push,
  output logic                   stk_pop,
  output logic [DW-1:0]          stk_wdata,
  input  logic [DW-1:0]          stk_rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int unsigned   CW      = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {IDLE, EXEC, WAIT, RESP} state_t;

  state_t        r_state;
  logic          r_prio_b;   // 1: B wins the next simultaneous request
  logic          r_sel_b;    // latched winner
  logic          r_op;       // latched op of the winner
  logic [CW-1:0] r_count;
  logic          r_stk_push;
  logic          r_stk_pop;
  logic [DW-1:0] r_stk_wdata;
  logic          r_a_ack;
  logic          r_a_err;
  logic [DW-1:0] r_a_rdata;
  logic          r_b_ack;
  logic          r_b_err;
  logic [DW-1:0] r_b_rdata;

  logic          w_any;
  logic          w_grant_b;
  logic          w_op;
  logic [DW-1:0] w_wdata;
  logic          w_legal;

  assign w_any     = a_req | b_req;
  assign w_grant_b = b_req & (~a_req | r_prio_b);
  assign w_op      = w_grant_b ? b_op : a_op;
  assign w_wdata   = w_grant_b ? b_wdata : a_wdata;
  assign w_legal   = w_op ? (r_count != '0) : (r_count != DEPTH_C);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_prio_b    <= 1'b0;
      r_sel_b     <= 1'b0;
      r_op        <= 1'b0;
      r_count     <= '0;
      r_stk_push  <= 1'b0;
      r_stk_pop   <= 1'b0;
      r_stk_wdata <= '0;
      r_a_ack     <= 1'b0;
      r_a_err     <= 1'b0;
      r_a_rdata   <= '0;
      r_b_ack     <= 1'b0;
      r_b_err     <= 1'b0;
      r_b_rdata   <= '0;
    end else begin
      // Strobes and response fields are single-cycle pulses by default.
      r_stk_push <= 1'b0;
      r_stk_pop  <= 1'b0;
      r_a_ack    <= 1'b0;
      r_a_err    <= 1'b0;
      r_a_rdata  <= '0;
      r_b_ack    <= 1'b0;
      r_b_err    <= 1'b0;
      r_b_rdata  <= '0;
      unique case (r_state)
        IDLE: begin
          if (ena && w_any) begin
            r_sel_b  <= w_grant_b;
            r_op     <= w_op;
            r_prio_b <= ~w_grant_b;
            if (w_legal) begin
              r_state    <= EXEC;
              r_stk_push <= ~w_op;
              r_stk_pop  <= w_op;
              if (!w_op) r_stk_wdata <= w_wdata;
            end else begin
              // Rejected ops skip the datapath and answer in the next cycle.
              r_state <= RESP;
              r_a_ack <= ~w_grant_b;
              r_a_err <= ~w_grant_b;
              r_b_ack <= w_grant_b;
              r_b_err <= w_grant_b;
            end
          end
        end
        EXEC: begin
          r_count <= r_op ? (r_count - 1'b1) : (r_count + 1'b1);
          r_state <= WAIT;
        end
        WAIT: begin
          // Pop data arrives this cycle; register it with the ack so both
          // appear together in RESP.
          r_a_ack   <= ~r_sel_b;
          r_b_ack   <= r_sel_b;
          r_a_rdata <= (r_op && !r_sel_b) ? stk_rdata : '0;
          r_b_rdata <= (r_op &&  r_sel_b) ? stk_rdata : '0;
          r_state   <= RESP;
        end
        RESP: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign a_ack     = r_a_ack;
  assign a_err     = r_a_err;
  assign a_rdata   = r_a_rdata;
  assign b_ack     = r_b_ack;
  assign b_err     = r_b_err;
  assign b_rdata   = r_b_rdata;
  assign stk_push  = r_stk_push;
  assign stk_pop   = r_stk_pop;
  assign stk_wdata = r_stk_wdata;
  assign count     = r_count;
  assign full      = (r_count == DEPTH_C);
  assign empty     = (r_count == '0);

endmodule
